// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_if
//  Description : Bundles the request/response handshake between the core's
//                memory stage and the load/store unit, together with the
//                word-addressed RAM data port that the unit drives.
//                  slave  - the load/store unit's view
//                  master - the environment's view (core request side plus
//                           the RAM, which returns d_read_data)
//  Ports       : req_valid/req_ready/req_write/req_size/req_unsigned/
//                req_address/req_wdata  - request handshake and payload
//                resp_valid/resp_rdata/resp_misaligned - completion pulse
//                d_address/d_read_data/d_write_data/wEn - RAM data port
//  Revision    : 1.0  initial release
// ============================================================================
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [31:0]           req_address;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_misaligned;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [31:0]           d_read_data;
  logic [31:0]           d_write_data;
  logic                  wEn;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_address, req_wdata,
    input  d_read_data,
    output req_ready, resp_valid, resp_rdata, resp_misaligned,
    output d_address, d_write_data, wEn
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_address, req_wdata,
    output d_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned,
    input  d_address, d_write_data, wEn
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Data-side load/store unit. Converts byte/half/word requests
//                at 32-bit byte addresses into accesses on a word-addressed
//                RAM port. Sub-word loads are lane-selected and sign/zero
//                extended; sub-word stores use read-modify-write because the
//                RAM only has a whole-word write enable. Misaligned requests
//                are answered with an error and never touch memory.
//  Ports       : clock - rising-edge clock
//                reset - asynchronous active-low reset
//                bus   - load_store_unit_if.slave (request, response and
//                        RAM data port signals)
//  Revision    : 1.0  initial release
// ============================================================================
module load_store_unit #(
  parameter int ADDR_WIDTH = 16
) (
  input  wire logic         clock,
  input  wire logic         reset,
  load_store_unit_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STORE  = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  localparam logic [1:0] c_size_byte = 2'b00;
  localparam logic [1:0] c_size_half = 2'b01;
  localparam logic [1:0] c_size_word = 2'b10;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_off;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  // Holds the store data after accept and is overwritten with the merged
  // word during RMW_RD, so d_write_data always comes straight from it.
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_misaligned;

  logic [1:0]            w_req_off;
  logic                  w_req_misaligned;
  logic [31:0]           w_shifted;
  logic [31:0]           w_load_value;
  logic [31:0]           w_lane_mask;
  logic [31:0]           w_lane_data;
  logic [31:0]           w_merged;
  logic                  w_unused_addr_hi;

  // Address bits above the RAM's reach are deliberately dropped (aliasing).
  assign w_unused_addr_hi = ^bus.req_address[31:ADDR_WIDTH+2];

  assign w_req_off        = bus.req_address[1:0];
  assign w_req_misaligned = (bus.req_size == 2'b11) ||
                            ((bus.req_size == c_size_half) && w_req_off[0]) ||
                            ((bus.req_size == c_size_word) && (w_req_off != 2'b00));

  // Load lane select and extension.
  always_comb begin
    w_shifted    = bus.d_read_data >> {r_off, 3'b000};
    w_load_value = bus.d_read_data;
    case (r_size)
      c_size_byte: w_load_value = {{24{~r_unsigned & w_shifted[7]}},  w_shifted[7:0]};
      c_size_half: w_load_value = {{16{~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default:     w_load_value = bus.d_read_data;
    endcase
  end

  // Read-modify-write merge: replicate the new byte/half across all lanes
  // and let the shifted mask pick the addressed one.
  always_comb begin
    w_lane_mask = 32'h0000_0000;
    w_lane_data = 32'h0000_0000;
    if (r_size == c_size_byte) begin
      w_lane_mask = 32'h0000_00FF << {r_off, 3'b000};
      w_lane_data = {4{r_wdata[7:0]}};
    end else begin
      w_lane_mask = 32'h0000_FFFF << {r_off, 3'b000};
      w_lane_data = {2{r_wdata[15:0]}};
    end
    w_merged = (bus.d_read_data & ~w_lane_mask) | (w_lane_data & w_lane_mask);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_off        <= 2'b00;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_wdata      <= 32'h0000_0000;
      r_rdata      <= 32'h0000_0000;
      r_misaligned <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_addr     <= bus.req_address[ADDR_WIDTH+1:2];
            r_off      <= w_req_off;
            r_size     <= bus.req_size;
            r_unsigned <= bus.req_unsigned;
            r_wdata    <= bus.req_wdata;
            if (w_req_misaligned) begin
              r_rdata      <= 32'h0000_0000;
              r_misaligned <= 1'b1;
              r_state      <= S_RESP;
            end else if (!bus.req_write) begin
              r_state <= S_LOAD;
            end else if (bus.req_size == c_size_word) begin
              r_state <= S_STORE;
            end else begin
              r_state <= S_RMW_RD;
            end
          end
        end
        // Response registers only change on the edge entering RESP, so they
        // hold their value from one response to the next.
        S_LOAD: begin
          r_rdata      <= w_load_value;
          r_misaligned <= 1'b0;
          r_state      <= S_RESP;
        end
        S_STORE: begin
          r_rdata      <= 32'h0000_0000;
          r_misaligned <= 1'b0;
          r_state      <= S_RESP;
        end
        S_RMW_RD: begin
          r_wdata <= w_merged;
          r_state <= S_RMW_WR;
        end
        S_RMW_WR: begin
          r_rdata      <= 32'h0000_0000;
          r_misaligned <= 1'b0;
          r_state      <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Decoded purely from the state register, so an asynchronous reset drops
  // wEn immediately and no write lands on the following edge.
  assign bus.req_ready       = (r_state == S_IDLE);
  assign bus.resp_valid      = (r_state == S_RESP);
  assign bus.wEn             = (r_state == S_STORE) || (r_state == S_RMW_WR);
  assign bus.resp_rdata      = r_rdata;
  assign bus.resp_misaligned = r_misaligned;
  assign bus.d_address       = r_addr;
  assign bus.d_write_data    = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Self-checking bench for load_store_unit. A byte-array
//                reference memory predicts load results, store effects,
//                misalignment errors and latencies for directed and random
//                requests; a word array models the RAM behind the DUT.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_load_store_unit;
  localparam int AW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_WIDTH(AW)) bus ();
  load_store_unit #(.ADDR_WIDTH(AW)) dut (.clock(clk), .reset(rst_n), .bus(bus));

  logic [31:0] ram [0:65535];
  assign bus.d_read_data = ram[bus.d_address];
  always @(posedge clk) if (bus.wEn) ram[bus.d_address] <= bus.d_write_data;

  // Reference memory: plain little-endian bytes, byte address 0..1023.
  logic [7:0] ref_mem [0:1023];

  int checks = 0;
  int errors = 0;
  int resp_cnt = 0;
  int cyc = 0;
  logic [31:0] resp_q [$];

  always @(posedge clk) cyc++;
  always @(negedge clk) if (bus.resp_valid) begin
    resp_cnt++;
    resp_q.push_back(bus.resp_rdata);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
  endfunction

  task automatic set_word(input int w, input logic [31:0] v);
    ram[w] = v;
    for (int i = 0; i < 4; i++) ref_mem[4*w+i] = v[8*i +: 8];
  endtask

  function automatic logic ref_mis(input logic [1:0] sz, input logic [1:0] off);
    return (sz == 2'd3) || (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    int n = 1 << sz;
    int base = int'(a[9:0]);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base+i]) << (8*i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int n = 1 << sz;
    int base = int'(a[9:0]);
    for (int i = 0; i < n; i++) ref_mem[base+i] = wd[8*i +: 8];
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/req_ready"},       32'(bus.req_ready), 32'd1);
    check({tag, "/resp_valid"},      32'(bus.resp_valid), 32'd0);
    check({tag, "/resp_rdata"},      bus.resp_rdata, 32'd0);
    check({tag, "/resp_misaligned"}, 32'(bus.resp_misaligned), 32'd0);
    check({tag, "/wEn"},             32'(bus.wEn), 32'd0);
    check({tag, "/d_address"},       32'(bus.d_address), 32'd0);
    check({tag, "/d_write_data"},    bus.d_write_data, 32'd0);
  endtask

  // One complete request, checked against the reference model.
  task automatic txn(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output int wen_at);
    int lat, wen_cnt, w, exp_lat;
    logic got, mis_exp;
    logic [31:0] exp_rd, junk;
    mis_exp = ref_mis(sz, addr[1:0]);
    exp_rd  = (wr || mis_exp) ? 32'h0 : ref_load(addr, sz, uns);
    exp_lat = mis_exp ? 1 : (wr && sz != 2'd2) ? 3 : 2;
    @(negedge clk);
    lat = 0;
    while (!bus.req_ready && lat < 10) begin @(negedge clk); lat++; end
    check({tag, "/ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_address = addr; bus.req_wdata = wd;
    @(posedge clk);
    #1;
    // Scramble the request inputs: only the latched copies may matter.
    junk = $urandom;
    bus.req_valid = 1'b0; bus.req_write = junk[0]; bus.req_size = junk[2:1];
    bus.req_unsigned = junk[3]; bus.req_address = $urandom; bus.req_wdata = $urandom;
    lat = 0; wen_cnt = 0; wen_at = 0; got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (bus.wEn) begin
        wen_cnt++;
        if (wen_at == 0) wen_at = lat;
      end
      if (bus.resp_valid) got = 1'b1;
    end
    rd = bus.resp_rdata;
    check({tag, "/latency"},    32'(lat), 32'(exp_lat));
    check({tag, "/rdata"},      rd, exp_rd);
    check({tag, "/misaligned"}, 32'(bus.resp_misaligned), 32'(mis_exp));
    check({tag, "/wen_cycles"}, 32'(wen_cnt), (wr && !mis_exp) ? 32'd1 : 32'd0);
    check({tag, "/ready_in_resp"}, 32'(bus.req_ready), 32'd0);
    if (wr && !mis_exp) ref_store(addr, sz, wd);
    w = int'(addr[9:2]);
    check({tag, "/mem"}, ram[w], ref_word(w));
  endtask

  logic [31:0] rd, w1_save, w3_save, hi, lo, exp_b [4];
  int wen_at, rc, n;
  int acc [4];

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_address = 32'h0; bus.req_wdata = 32'h0;
    for (int i = 0; i < 65536; i++) ram[i] = 32'h0;
    for (int i = 0; i < 256; i++) set_word(i, $urandom);

    // Reset state
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Byte / half loads
    set_word(1, 32'h8899_AABB);
    txn("lb_signed", 1'b0, 2'd0, 1'b0, 32'h5, 32'h0, rd, wen_at);
    check("lb_signed/const", rd, 32'hFFFF_FFAA);
    txn("lbu", 1'b0, 2'd0, 1'b1, 32'h5, 32'h0, rd, wen_at);
    check("lbu/const", rd, 32'h0000_00AA);
    txn("lh_signed", 1'b0, 2'd1, 1'b0, 32'h6, 32'h0, rd, wen_at);
    check("lh_signed/const", rd, 32'hFFFF_8899);

    // Halfword store via read-modify-write
    txn("sh_rmw", 1'b1, 2'd1, 1'b0, 32'h6, 32'h0000_1234, rd, wen_at);
    check("sh_rmw/wen_cycle", 32'(wen_at), 32'd2);
    check("sh_rmw/ram1", ram[1], 32'h1234_AABB);

    // Word store then load
    set_word(3, 32'h1357_2468);
    w1_save = ram[1]; w3_save = ram[3];
    txn("sw", 1'b1, 2'd2, 1'b0, 32'h8, 32'hDEAD_BEEF, rd, wen_at);
    txn("lw", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, rd, wen_at);
    check("lw/const", rd, 32'hDEAD_BEEF);
    check("sw/ram1_kept", ram[1], w1_save);
    check("sw/ram3_kept", ram[3], w3_save);

    // Misaligned requests
    txn("mis_lw", 1'b0, 2'd2, 1'b0, 32'h6, 32'h0, rd, wen_at);
    txn("mis_sh", 1'b1, 2'd1, 1'b0, 32'h3, 32'hCAFE_F00D, rd, wen_at);
    check("mis_sh/ram0_kept", ram[0], ref_word(0));

    // Reset during RMW_WR of a byte store
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_address = 32'h4; bus.req_wdata = 32'h55;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_rmw/wen_before", 32'(bus.wEn), 32'd1);
    rc = resp_cnt;
    rst_n = 1'b0;
    #1 check_reset_outputs("rst_rmw");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_rmw/no_resp", 32'(resp_cnt), 32'(rc));
    check("rst_rmw/ram1", ram[1], ref_word(1));
    check("rst_rmw/ready", 32'(bus.req_ready), 32'd1);

    // Back-to-back with req_valid held: load, byte store, load, load
    exp_b[0] = ref_load(32'h8, 2'd2, 1'b0);
    ref_store(32'h9, 2'd0, 32'hA5);
    exp_b[1] = 32'h0;
    exp_b[2] = ref_load(32'h8, 2'd2, 1'b0);
    exp_b[3] = ref_load(32'h4, 2'd2, 1'b0);
    resp_q.delete();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      bus.req_valid = 1'b1;
      bus.req_write = (k == 1);
      bus.req_size  = (k == 1) ? 2'd0 : 2'd2;
      bus.req_unsigned = 1'b0;
      bus.req_address = (k == 1) ? 32'h9 : (k == 3) ? 32'h4 : 32'h8;
      bus.req_wdata = 32'h0000_00A5;
      n = 0;
      while (!bus.req_ready && n < 10) begin @(negedge clk); n++; end
      acc[k] = cyc;
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("b2b/spacing_load",   32'(acc[1] - acc[0]), 32'd3);
    check("b2b/spacing_sb",     32'(acc[2] - acc[1]), 32'd4);
    check("b2b/spacing_load2",  32'(acc[3] - acc[2]), 32'd3);
    check("b2b/resp_count", 32'(resp_q.size()), 32'd4);
    for (int k = 0; k < 4 && k < resp_q.size(); k++) check($sformatf("b2b/resp%0d", k), resp_q[k], exp_b[k]);
    check("b2b/ram2", ram[2], ref_word(2));

    // Random requests, high address bits randomised to exercise aliasing
    for (int i = 0; i < 60; i++) begin
      hi = $urandom;
      lo = $urandom_range(0, 1023);
      txn($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), {hi[13:0], 8'h00, lo[9:0]}, $urandom, rd, wen_at);
    end
    for (int w = 0; w < 256; w++) check($sformatf("final_mem%0d", w), ram[w], ref_word(w));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
